x2g_ctrl: RTL

Receive-side counterpart of the GigE-to-XGMII transmit controller. Takes a 64-bit XGMII-style word stream (8 lanes, per-lane ctrl bit) and writes each packet, start word through terminate word inclusive, into the gige data FIFO. After the last word it pushes the packet byte count into the gige bcnt FIFO, in the format the FIFO reader uses to compute quad-word count as ceil(bcnt/8). Performs admission control, overflow/length protection and keeps packet/drop statistics.

---
 rtl/x2g_ctrl_if.sv | 24 ++
 rtl/x2g_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/x2g_ctrl_if.sv
// XGMII-receive to gige FIFO bus bundle: inbound word stream, FIFO status flags
// and the registered data/bcnt FIFO write ports.
interface x2g_ctrl_if;
  logic [63:0] data_in;
  logic [7:0]  ctrl_in;
  logic        data_fifo_afull;
  logic        data_fifo_full;
  logic        bcnt_fifo_full;
  logic        data_fifo_we;
  logic [63:0] data_out;
  logic [7:0]  ctrl_out;
  logic        bcnt_fifo_we;
  logic [15:0] bcnt_out;

  modport master (
    output data_in, ctrl_in, data_fifo_afull, data_fifo_full, bcnt_fifo_full,
    input  data_fifo_we, data_out, ctrl_out, bcnt_fifo_we, bcnt_out
  );

  modport slave (
    input  data_in, ctrl_in, data_fifo_afull, data_fifo_full, bcnt_fifo_full,
    output data_fifo_we, data_out, ctrl_out, bcnt_fifo_we, bcnt_out
  );
endinterface

// File: rtl/x2g_ctrl.sv
// XGMII receive controller: writes start..terminate words into the gige data FIFO,
// then the packet byte count into the bcnt FIFO; admission, overflow and length guards.
module x2g_ctrl #(
  parameter logic [15:0] MAX_QWD = 16'd2048
) (
  input  logic        clk,
  input  logic        reset_,
  x2g_ctrl_if.slave   bus,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt,
  output logic        ovf_err,
  output logic        len_err
);

  localparam logic [63:0] IDLE_DATA  = 64'h0707_0707_0707_0707;
  localparam logic [7:0]  IDLE_CTRL  = 8'hff;
  localparam logic [2:0]  ST_IDLE    = 3'b001;
  localparam logic [2:0]  ST_PKT     = 3'b010;
  localparam logic [2:0]  ST_DROP    = 3'b100;
  localparam logic [15:0] TRUNC_BCNT = MAX_QWD << 3'd3;

  logic [2:0]  state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        dwe_q, dwe_d;
  logic [63:0] dout_q, dout_d;
  logic [7:0]  cout_q, cout_d;
  logic        bwe_q, bwe_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        ovf_q, ovf_d;
  logic        len_q, len_d;

  logic        sop;
  logic        l4_start;
  logic [7:0]  hit;
  logic        term;
  logic [2:0]  t_lane;

  // Per-word decode of start and terminate control characters
  always_comb begin
    sop      = bus.ctrl_in[0] && (bus.data_in[7:0] == 8'hFB);
    l4_start = bus.ctrl_in[4] && (bus.data_in[39:32] == 8'hFB) && !sop;
    for (int i = 0; i < 8; i++) begin
      hit[i] = bus.ctrl_in[i] && (bus.data_in[8*i +: 8] == 8'hFD);
    end
    term = |hit;
    casez (hit)
      8'b???????1: t_lane = 3'd0;
      8'b??????10: t_lane = 3'd1;
      8'b?????100: t_lane = 3'd2;
      8'b????1000: t_lane = 3'd3;
      8'b???10000: t_lane = 3'd4;
      8'b??100000: t_lane = 3'd5;
      8'b?1000000: t_lane = 3'd6;
      8'b10000000: t_lane = 3'd7;
      default:     t_lane = 3'd0;
    endcase
  end

  logic        accept;
  logic        ovf_hit;
  logic        start_rej;
  logic        rej_to_idle;
  logic [15:0] wcnt_inc;
  logic [15:0] term_bcnt;

  // Classify the current word and precompute byte counts
  always_comb begin
    accept      = 1'b0;
    ovf_hit     = 1'b0;
    start_rej   = 1'b0;
    rej_to_idle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sop) begin
          accept      = !bus.data_fifo_afull && !bus.bcnt_fifo_full;
          start_rej   = bus.data_fifo_afull || bus.bcnt_fifo_full;
          rej_to_idle = term;
        end else if (l4_start) begin
          start_rej   = 1'b1;
          // a terminate above the lane-4 start closes the rejected frame in this word
          rej_to_idle = term && (t_lane > 3'd4);
        end else begin
          start_rej   = 1'b0;
        end
      end
      ST_PKT: begin
        accept  = !bus.data_fifo_full;
        ovf_hit = bus.data_fifo_full;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
    if (state_q == ST_PKT) begin
      wcnt_inc = wcnt_q + 16'd1;
    end else begin
      wcnt_inc = 16'd1;
    end
    term_bcnt = ((wcnt_inc - 16'd1) << 3'd3) + {13'd0, t_lane} + 16'd1;
  end

  // Next-state, FIFO write and statistics logic
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dwe_d      = 1'b0;
    dout_d     = IDLE_DATA;
    cout_d     = IDLE_CTRL;
    bwe_d      = 1'b0;
    bcnt_d     = 16'd0;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    len_d      = 1'b0;
    if (accept) begin
      dwe_d  = 1'b1;
      dout_d = bus.data_in;
      cout_d = bus.ctrl_in;
      if (term) begin
        bwe_d     = 1'b1;
        bcnt_d    = term_bcnt;
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        state_d   = ST_IDLE;
        wcnt_d    = 16'd0;
      end else if (wcnt_inc == MAX_QWD) begin
        bwe_d     = 1'b1;
        bcnt_d    = TRUNC_BCNT;
        len_d     = 1'b1;
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        state_d   = ST_DROP;
        wcnt_d    = 16'd0;
      end else begin
        state_d   = ST_PKT;
        wcnt_d    = wcnt_inc;
      end
    end else if (ovf_hit) begin
      // close the packet with what actually reached the FIFO so the reader stays aligned
      bwe_d     = 1'b1;
      bcnt_d    = wcnt_q << 3'd3;
      ovf_d     = 1'b1;
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      state_d   = term ? ST_IDLE : ST_DROP;
      wcnt_d    = 16'd0;
    end else if (start_rej) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
      state_d    = rej_to_idle ? ST_IDLE : ST_DROP;
      wcnt_d     = 16'd0;
    end else if (state_q == ST_DROP) begin
      state_d = term ? ST_IDLE : ST_DROP;
      wcnt_d  = 16'd0;
    end else begin
      state_d = ST_IDLE;
      wcnt_d  = 16'd0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 16'd0;
      dwe_q      <= 1'b0;
      dout_q     <= IDLE_DATA;
      cout_q     <= IDLE_CTRL;
      bwe_q      <= 1'b0;
      bcnt_q     <= 16'd0;
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
      ovf_q      <= 1'b0;
      len_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dwe_q      <= dwe_d;
      dout_q     <= dout_d;
      cout_q     <= cout_d;
      bwe_q      <= bwe_d;
      bcnt_q     <= bcnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      len_q      <= len_d;
    end
  end

  assign bus.data_fifo_we = dwe_q;
  assign bus.data_out     = dout_q;
  assign bus.ctrl_out     = cout_q;
  assign bus.bcnt_fifo_we = bwe_q;
  assign bus.bcnt_out     = bcnt_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign drop_cnt         = drop_cnt_q;
  assign ovf_err          = ovf_q;
  assign len_err          = len_q;

endmodule
